// File: rtl/vlib_psum_accumulator_if.sv
// rtl/vlib_psum_accumulator_if.sv - tree-result input, config and result handshake bundle
interface vlib_psum_accumulator_if #(
    parameter int IN_WIDTH  = 11,
    parameter int ACC_WIDTH = 24,
    parameter int GRP_WIDTH = 8
);
    logic                        clear;
    logic [GRP_WIDTH-1:0]        cfg_groups;
    logic                        valid_in;
    logic                        ready_in;
    logic signed [IN_WIDTH-1:0]  in;
    logic                        valid_out;
    logic                        ready_out;
    logic signed [ACC_WIDTH-1:0] res;
    logic                        ovf;
    logic [GRP_WIDTH-1:0]        grp_cnt;

    modport master (
        output clear, cfg_groups, valid_in, in, ready_out,
        input  ready_in, valid_out, res, ovf, grp_cnt
    );

    modport slave (
        input  clear, cfg_groups, valid_in, in, ready_out,
        output ready_in, valid_out, res, ovf, grp_cnt
    );
endinterface

// File: rtl/vlib_psum_accumulator.sv
// rtl/vlib_psum_accumulator.sv - accumulates adder-tree sums over a programmable number of channel groups
module vlib_psum_accumulator #(
    parameter int IN_WIDTH  = 11,
    parameter int ACC_WIDTH = 24,
    parameter int GRP_WIDTH = 8,
    parameter bit SATURATE  = 1'b1
) (
    input logic clk,
    input logic rst,
    vlib_psum_accumulator_if.slave bus
);
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                      state;
    state_t                      state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] res;
    logic signed [ACC_WIDTH-1:0] sum_fit;
    logic signed [SW-1:0]        addend;
    logic signed [SW-1:0]        base;
    logic signed [SW-1:0]        sum;
    logic [GRP_WIDTH-1:0]        grp_cnt;
    logic [GRP_WIDTH-1:0]        grp_lim;
    logic [GRP_WIDTH-1:0]        cfg_lim;
    logic [GRP_WIDTH-1:0]        grp_inc;
    logic                        sticky;
    logic                        sticky_in;
    logic                        valid_out;
    logic                        ovf;
    logic                        ready_in;
    logic                        accept;
    logic                        last;
    logic                        ovf_now;
    logic                        load;

    assign ready_in  = !(valid_out && !bus.ready_out);
    assign accept    = bus.valid_in && ready_in;
    assign cfg_lim   = (bus.cfg_groups == '0) ? GRP_WIDTH'(1) : bus.cfg_groups;
    assign grp_inc   = grp_cnt + GRP_WIDTH'(1);

    // The first beat of an accumulation starts from zero, so a stale acc never leaks in.
    assign addend    = SW'(bus.in);
    assign base      = (state == ACCUM) ? SW'(acc) : '0;
    assign sum       = base + addend;
    assign ovf_now   = sum[SW-1] ^ sum[SW-2];
    assign sticky_in = (state == ACCUM) && sticky;

    always_comb begin
        sum_fit = sum[ACC_WIDTH-1:0];
        if (ovf_now && SATURATE) begin
            sum_fit = sum[SW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    assign last = (state == IDLE) ? (cfg_lim == GRP_WIDTH'(1)) : (grp_inc == grp_lim);
    assign load = accept && last && !bus.clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            grp_cnt <= '0;
            grp_lim <= GRP_WIDTH'(1);
            sticky  <= 1'b0;
        end else if (bus.clear) begin
            acc     <= '0;
            grp_cnt <= '0;
            sticky  <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                grp_lim <= cfg_lim;
            end
            acc     <= last ? '0 : sum_fit;
            sticky  <= last ? 1'b0 : (sticky_in | ovf_now);
            grp_cnt <= last ? '0 : grp_inc;
        end
    end

    // A new result may load in the same cycle the previous one drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            res       <= '0;
            ovf       <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            res       <= sum_fit;
            ovf       <= sticky_in | ovf_now;
        end else if (bus.ready_out) begin
            valid_out <= 1'b0;
        end
    end

    assign bus.ready_in  = ready_in;
    assign bus.valid_out = valid_out;
    assign bus.res       = res;
    assign bus.ovf       = ovf;
    assign bus.grp_cnt   = grp_cnt;
endmodule

// File: tb/tb_vlib_psum_accumulator.sv
// tb/tb_vlib_psum_accumulator.sv - scoreboard bench driving saturating and wrapping instances together
module tb_vlib_psum_accumulator;
    localparam int IW = 11;
    localparam int AW = 12;
    localparam int GW = 8;

    typedef struct {
        int     res;
        bit     ovf;
        longint due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 clear     = 1'b0;
    logic [GW-1:0]        cfg       = '0;
    logic                 valid_in  = 1'b0;
    logic signed [IW-1:0] din       = '0;
    logic                 ready_out = 1'b0;

    vlib_psum_accumulator_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .GRP_WIDTH(GW)) ifs ();
    vlib_psum_accumulator_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .GRP_WIDTH(GW)) ifw ();

    assign ifs.clear = clear;  assign ifs.cfg_groups = cfg;  assign ifs.valid_in = valid_in;
    assign ifs.in = din;       assign ifs.ready_out = ready_out;
    assign ifw.clear = clear;  assign ifw.cfg_groups = cfg;  assign ifw.valid_in = valid_in;
    assign ifw.in = din;       assign ifw.ready_out = ready_out;

    vlib_psum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .GRP_WIDTH(GW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .bus(ifs.slave));
    vlib_psum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .GRP_WIDTH(GW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .bus(ifw.slave));

    exp_t   qs[$];
    exp_t   qw[$];
    int     vals[$];
    int     lim = 1;
    int     exp_grp = 0;
    int     exp_grp_next = 0;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     ro_mode = 0;
    bit     mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_grp = rst ? 0 : exp_grp_next;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_out = (ro_mode == 1) || (ro_mode == 2 && $urandom_range(0, 3) != 0);
        end
    end

    // Reference: each accumulation step adds the next value, then clamps or wraps into 12 bits.
    function automatic void fold(input bit sat, output int s, output bit o);
        s = 0;
        o = 1'b0;
        foreach (vals[k]) begin
            s += vals[k];
            if (s > 2047) begin
                o = 1'b1;
                s = sat ? 2047 : s - 4096;
            end else if (s < -2048) begin
                o = 1'b1;
                s = sat ? -2048 : s + 4096;
            end
        end
    endfunction

    task automatic model_accept(input int v, input int g);
        exp_t e;
        if (vals.size() == 0) lim = (g == 0) ? 1 : g;
        vals.push_back(v);
        if (vals.size() == lim) begin
            e.due = cyc + 1;
            fold(1'b1, e.res, e.ovf);
            qs.push_back(e);
            fold(1'b0, e.res, e.ovf);
            qw.push_back(e);
            vals.delete();
            exp_grp_next = 0;
        end else begin
            exp_grp_next = vals.size();
        end
    endtask

    task automatic mon_one(input int i, input logic v, input logic signed [AW-1:0] r, input logic o);
        exp_t e;
        int   n;
        n = (i == 0) ? qs.size() : qw.size();
        if (n == 0) begin
            chk($sformatf("idle_valid_out[%0d]", i), v, 0);
        end else begin
            e = (i == 0) ? qs[0] : qw[0];
            if (cyc < e.due) begin
                chk($sformatf("early_valid_out[%0d]", i), v, 0);
            end else begin
                chk($sformatf("valid_out[%0d]", i), v, 1);
                chk($sformatf("res[%0d]", i), r, e.res);
                chk($sformatf("ovf[%0d]", i), o, e.ovf);
                if (v && ready_out) begin
                    if (i == 0) void'(qs.pop_front());
                    else void'(qw.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                mon_one(0, ifs.valid_out, ifs.res, ifs.ovf);
                mon_one(1, ifw.valid_out, ifw.res, ifw.ovf);
                chk("grp_cnt[0]", ifs.grp_cnt, exp_grp);
                chk("grp_cnt[1]", ifw.grp_cnt, exp_grp);
            end
        end
    end

    task automatic beat(input int v, input int g);
        int waitc;
        bit done;
        waitc = 0;
        done  = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            clear    = 1'b0;
            valid_in = 1'b1;
            din      = v[IW-1:0];
            cfg      = g[GW-1:0];
            @(negedge clk);
            if (ifs.ready_in && ifw.ready_in) begin
                model_accept(v, g);
                done = 1'b1;
            end else begin
                waitc++;
                if (waitc > 200) begin
                    chk("beat_accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic clear_beat(input int v);
        @(posedge clk);
        #1;
        clear    = 1'b1;
        valid_in = 1'b1;
        din      = v[IW-1:0];
        @(negedge clk);
        vals.delete();
        exp_grp_next = 0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((qs.size() != 0 || qw.size() != 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_pending_s"}, qs.size(), 0);
        chk({name, "_pending_w"}, qw.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid_out_s"}, ifs.valid_out, 0);
        chk({name, "_valid_out_w"}, ifw.valid_out, 0);
        chk({name, "_res_s"}, ifs.res, 0);
        chk({name, "_res_w"}, ifw.res, 0);
        chk({name, "_ovf_s"}, ifs.ovf, 0);
        chk({name, "_grp_cnt_s"}, ifs.grp_cnt, 0);
        chk({name, "_grp_cnt_w"}, ifw.grp_cnt, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int g;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_ready_in", ifs.ready_in, 1);
        rst    = 1'b0;
        mon_en = 1'b1;

        ro_mode = 1;
        beat(10, 4); beat(-3, 4); beat(7, 4); beat(100, 4);
        idle();
        beat(-512, 0); beat(1023, 1);
        idle();
        beat(1023, 3); beat(1023, 3); beat(1023, 3);
        beat(1, 2); beat(1, 2);
        idle();
        wait_drain("directed");

        ro_mode = 0;
        repeat (2) @(posedge clk);
        fork
            begin
                beat(5, 2); beat(5, 2); beat(5, 2); beat(5, 2);
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!ifs.valid_out && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready_in_s", ifs.ready_in, 0);
                    chk("stall_ready_in_w", ifw.ready_in, 0);
                end
                ro_mode = 1;
            end
        join
        idle();
        wait_drain("backpressure");

        beat(20, 4); beat(30, 4);
        clear_beat(99);
        beat(1, 4); beat(2, 4); beat(3, 4); beat(4, 4);
        idle();
        wait_drain("clear");

        beat(7, 3); beat(7, 3);
        idle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        qs.delete();
        qw.delete();
        vals.delete();
        exp_grp_next = 0;
        exp_grp      = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        beat(7, 3); beat(7, 3); beat(7, 3);
        idle();
        wait_drain("after_reset");

        ro_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            g = $urandom_range(0, 6);
            if (i % 10 == 0) v = ($urandom_range(0, 1) != 0) ? 1023 : -1024;
            else v = $urandom_range(0, 2047) - 1024;
            beat(v, g);
        end
        idle();
        ro_mode = 1;
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vlib_psum_accumulator.md
Name: vlib_psum_accumulator

Overview:
- Sits directly downstream of the DLA adder tree.
- Consumes the tree's signed per-atomic-cube sums, one per valid beat.
- Accumulates them across a runtime-programmable number of channel groups (C / ATOMIC_C).
- Emits one wide partial-sum result per output pixel/kernel through a valid/ready output register with backpressure.

Parameters:
- IN_WIDTH, 11, width of signed tree result (BITWIDTH + clog2(ATOMIC_C) for 8/8 tree).
- ACC_WIDTH, 24, width of signed accumulator and output; must be >= IN_WIDTH.
- GRP_WIDTH, 8, width of group-count config and counter.
- SATURATE, 1, 1 = clamp accumulator to signed ACC_WIDTH range; 0 = two's-complement wrap.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLEAR  in  1  synchronous abort of current accumulation.
- CFG_GROUPS  in  GRP_WIDTH  beats per result; 0 treated as 1.
- VALID_IN  in  1  IN carries a tree result.
- READY_IN  out  1  block can accept a beat this cycle.
- IN  in  IN_WIDTH  signed tree result.
- VALID_OUT  out  1  RES holds a completed sum.
- READY_OUT  in  1  downstream accepts RES.
- RES  out  ACC_WIDTH  signed accumulated result.
- OVF  out  1  saturation/wrap occurred during the accumulation that produced RES.
- GRP_CNT  out  GRP_WIDTH  beats accepted in the current accumulation (debug).

Behaviour:
- Reset (RST high, async): acc=0, GRP_CNT=0, grp_lim=1, VALID_OUT=0, RES=0, OVF=0, state=IDLE. Outputs hold these values while RST is high.
- Accept: beat accepted when VALID_IN && READY_IN.
- READY_IN = !(VALID_OUT && !READY_OUT). A beat is accepted in the same cycle a held result drains.
- FSM states:
  - IDLE (GRP_CNT==0): on accept, latch grp_lim = max(CFG_GROUPS,1).
    - If grp_lim==1: produce result directly, stay IDLE.
    - Otherwise: acc = sext(IN), GRP_CNT=1, -> ACCUM.
  - ACCUM: each accept does acc = acc + sext(IN), GRP_CNT++.
    - Beat number grp_lim (last) loads the output register, GRP_CNT=0, -> IDLE.
  - CFG_GROUPS changes during ACCUM are ignored until the next IDLE acceptance.
- Arithmetic:
  - IN is sign-extended to ACC_WIDTH+1; the sum is computed at ACC_WIDTH+1.
  - Overflow condition: the sum's top two bits differ.
  - SATURATE=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: truncate.
  - Either way, set the internal sticky ovf for this accumulation. Sticky ovf clears when a new accumulation starts.
- Output register:
  - On the last beat: RES <= final sum (including last IN), OVF <= sticky | this-beat overflow, VALID_OUT <= 1 on the next edge. Latency is 1 cycle from last-beat acceptance.
  - RES/OVF stay stable while VALID_OUT && !READY_OUT.
  - VALID_OUT clears on handshake unless a new last beat is accepted in the same cycle; in that case RES reloads and VALID_OUT stays 1.
- CLEAR:
  - Forces acc=0, GRP_CNT=0, sticky ovf=0, state IDLE.
  - Does not touch VALID_OUT/RES/OVF.
  - A beat accepted in the same cycle as CLEAR is discarded.
- RST mid-accumulation discards the partial sum and any pending output; no spurious VALID_OUT after release.
- No combinational path from VALID_IN/IN to any output. The only combinational path is READY_OUT -> READY_IN.

Test Plan:
- CFG_GROUPS=4, IN=10,-3,7,100 on consecutive cycles, READY_OUT=1 -> VALID_OUT pulses 1 cycle after 4th beat, RES=114, OVF=0, GRP_CNT sequence 1,2,3,0.
- CFG_GROUPS=0 and 1, IN=-512 then 1023 back-to-back -> two results, RES=-512 then 1023, each 1 cycle after its beat.
- ACC_WIDTH=12, SATURATE=1, CFG_GROUPS=3, IN=1023,1023,1023 -> RES=2047, OVF=1. Next group 1,1 (CFG=2) -> RES=2, OVF=0. Repeat with SATURATE=0 -> RES=-1027 (3069 wrapped), OVF=1.
- CFG_GROUPS=2, READY_OUT=0, stream 4 beats of 5 -> first RES=10 held with VALID_OUT=1. READY_IN drops after 2nd beat; 3rd beat stalls. Raise READY_OUT -> handshake, 3rd/4th accepted, second RES=10. No beat lost or duplicated.
- CFG_GROUPS=4, two beats (20,30), CLEAR with a concurrent beat 99, then beats 1,2,3,4 -> single result RES=10; 20/30/99 never appear.
- CFG_GROUPS=3, two beats accepted, RST asserted asynchronously mid-cycle -> VALID_OUT=0, RES=0, GRP_CNT=0 immediately. After release, three beats of 7 -> RES=21.
